// File: rtl/stopwatch_lap_pkg.sv
// Shared types, display codes and single-digit BCD helpers for the stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [3:0] DP_CODE = 4'hA;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Returns {carry_out, digit}; carry_in = 0 passes the digit through.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic cin);
        if (!cin) return {1'b0, d};
        if (d >= BCD_MAX) return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

    // Returns {borrow_out, digit}; borrow_in = 0 passes the digit through.
    function automatic logic [4:0] bcd_dec(input logic [3:0] d, input logic bin);
        if (!bin) return {1'b0, d};
        if (d == 4'd0) return {1'b1, BCD_MAX};
        return {1'b0, d - 4'd1};
    endfunction

    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/stopwatch_lap_if.sv
// Control inputs and display/status outputs of the stopwatch as one bundle.
interface stopwatch_lap_if #(
    parameter int unsigned SEC_DIGITS = 2
);
    logic                        start_stop;
    logic                        lap;
    logic                        mode;
    logic                        load;
    logic [4*(SEC_DIGITS+1)-1:0] preset;
    logic [4*(SEC_DIGITS+2)-1:0] display_number;
    logic                        running;
    logic                        lap_active;
    logic                        overflow;
    logic                        done;

    modport master (
        output start_stop, lap, mode, load, preset,
        input  display_number, running, lap_active, overflow, done
    );

    modport slave (
        input  start_stop, lap, mode, load, preset,
        output display_number, running, lap_active, overflow, done
    );
endinterface

// File: rtl/stopwatch_lap_button_sync.sv
// Two-flop synchroniser for a raw button plus a registered one-cycle rising-edge pulse.
module button_sync (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    logic sync1, sync2, sync2_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
            pulse   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            sync2_d <= sync2;
            pulse   <= sync2 & ~sync2_d;
        end
    end
endmodule

// File: rtl/stopwatch_lap.sv
// BCD stopwatch / countdown timer with lap hold, 0.1 s prescaler and decimal-point display encoding.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 10_000_000,
    parameter int unsigned SEC_DIGITS = 2
) (
    input logic            clk,
    input logic            reset,
    stopwatch_lap_if.slave bus
);
    localparam int unsigned ND = SEC_DIGITS + 1;
    localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef logic [ND-1:0][3:0] digits_t;

    state_t        state, state_n;
    digits_t       count, count_n;
    digits_t       lap_reg, lap_reg_n;
    digits_t       cnt_inc, cnt_dec, cnt_tick, preset_sat, shown;
    logic [PW-1:0] presc, presc_n;
    logic          mode_q, mode_q_n;
    logic          overflow_q, overflow_n;
    logic          lap_active_q, lap_active_n;
    logic          ss_pulse, lap_pulse, tick, inc_wrap, dec_zero;

    button_sync u_ss_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.start_stop),
        .pulse (ss_pulse)
    );

    button_sync u_lap_sync (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.lap),
        .pulse (lap_pulse)
    );

    assign tick = (state == ST_RUN) && (presc == PW'(CLK_DIV - 1));

    // Ripple carry/borrow from tenths upward; the final carry marks the all-9s wrap.
    always_comb begin
        logic c;
        logic b;
        c       = 1'b1;
        b       = 1'b1;
        cnt_inc = '0;
        cnt_dec = '0;
        for (int unsigned i = 0; i < ND; i++) begin
            {c, cnt_inc[i]} = bcd_inc(count[i], c);
            {b, cnt_dec[i]} = bcd_dec(count[i], b);
        end
        inc_wrap = c;
        dec_zero = (cnt_dec == '0);
        cnt_tick = mode_q ? cnt_dec : cnt_inc;
    end

    for (genvar g = 0; g < ND; g++) begin : g_digit
        assign preset_sat[g] = bcd_sat(bus.preset[4*g +: 4]);
    end

    always_comb begin
        state_n      = state;
        count_n      = count;
        lap_reg_n    = lap_reg;
        presc_n      = presc;
        mode_q_n     = mode_q;
        overflow_n   = overflow_q;
        lap_active_n = lap_active_q;

        if (bus.load && state != ST_RUN) begin
            count_n      = preset_sat;
            presc_n      = '0;
            overflow_n   = 1'b0;
            lap_active_n = 1'b0;
            state_n      = ST_STOP;
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (ss_pulse) begin
                        if (!(bus.mode && count == '0)) begin
                            state_n  = ST_RUN;
                            mode_q_n = bus.mode;
                        end
                    end else if (lap_pulse) begin
                        if (lap_active_q) begin
                            lap_active_n = 1'b0;
                        end else begin
                            count_n    = '0;
                            overflow_n = 1'b0;
                        end
                    end
                end
                ST_RUN: begin
                    presc_n = tick ? '0 : presc + PW'(1);
                    if (tick) begin
                        count_n = cnt_tick;
                        if (!mode_q && inc_wrap) overflow_n = 1'b1;
                        if (mode_q && dec_zero) state_n = ST_DONE;
                    end
                    // start_stop overrides a same-cycle DONE; lap captures the post-tick value.
                    if (ss_pulse) begin
                        state_n = ST_STOP;
                    end else if (lap_pulse) begin
                        if (lap_active_q) begin
                            lap_active_n = 1'b0;
                        end else begin
                            lap_reg_n    = count_n;
                            lap_active_n = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (ss_pulse) state_n = ST_STOP;
                end
                default: state_n = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_STOP;
            count        <= '0;
            lap_reg      <= '0;
            presc        <= '0;
            mode_q       <= 1'b0;
            overflow_q   <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            lap_reg      <= lap_reg_n;
            presc        <= presc_n;
            mode_q       <= mode_q_n;
            overflow_q   <= overflow_n;
            lap_active_q <= lap_active_n;
        end
    end

    assign shown              = lap_active_q ? lap_reg : count;
    assign bus.display_number = {shown[ND-1:1], DP_CODE, shown[0]};
    assign bus.running        = (state == ST_RUN);
    assign bus.done           = (state == ST_DONE);
    assign bus.overflow       = overflow_q;
    assign bus.lap_active     = lap_active_q;
endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed scoreboard bench for stopwatch_lap with CLK_DIV=1, SEC_DIGITS=2.
module tb_stopwatch_lap;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int unsigned checks   = 0;
    int unsigned failures = 0;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    stopwatch_lap_if #(.SEC_DIGITS(2)) bus ();

    stopwatch_lap #(.CLK_DIV(1), .SEC_DIGITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic expect_val(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [15:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_disp(input string tag, input logic [15:0] v);
        expect_val(tag, v);
        check(bus.display_number);
    endtask

    task automatic chk_flag(input string tag, input logic obs, input logic v);
        expect_val(tag, {15'd0, v});
        check({15'd0, obs});
    endtask

    // Called at a negedge; returns at the negedge after the pulse has been consumed.
    task automatic press(input logic ss, input logic lp);
        bus.start_stop = ss;
        bus.lap        = lp;
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_load(input logic [11:0] p);
        bus.preset = p;
        bus.load   = 1'b1;
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    initial begin
        bus.start_stop = 1'b0;
        bus.lap        = 1'b0;
        bus.mode       = 1'b0;
        bus.load       = 1'b0;
        bus.preset     = '0;

        #1 reset = 1'b1;
        #1;
        chk_disp("rst_disp", 16'h00A0);
        chk_flag("rst_running", bus.running, 1'b0);
        chk_flag("rst_done", bus.done, 1'b0);
        chk_flag("rst_ovf", bus.overflow, 1'b0);
        chk_flag("rst_lap", bus.lap_active, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: 25 ticks then stop
        press(1'b1, 1'b0);
        repeat (21) @(negedge clk);
        press(1'b1, 1'b0);
        chk_disp("t1_disp", 16'h02A5);
        chk_flag("t1_running", bus.running, 1'b0);
        repeat (5) @(negedge clk);
        chk_disp("t1_hold", 16'h02A5);

        // 2: clear via lap in STOP, count to all-9s and wrap
        press(1'b0, 1'b1);
        chk_disp("t2_clear", 16'h0000 | 16'h00A0);
        press(1'b1, 1'b0);
        repeat (999) @(negedge clk);
        chk_disp("t2_999", 16'h99A9);
        chk_flag("t2_ovf_pre", bus.overflow, 1'b0);
        @(negedge clk);
        chk_disp("t2_wrap", 16'h00A0);
        chk_flag("t2_ovf", bus.overflow, 1'b1);
        chk_flag("t2_running", bus.running, 1'b1);
        press(1'b1, 1'b0);
        chk_disp("t2_stop", 16'h00A4);

        // 3: count-down from preset
        bus.mode = 1'b1;
        do_load(12'h015);
        chk_disp("t3_load", 16'h01A5);
        chk_flag("t3_ovf_clr", bus.overflow, 1'b0);
        press(1'b1, 1'b0);
        chk_flag("t3_running", bus.running, 1'b1);
        repeat (14) @(negedge clk);
        chk_disp("t3_one", 16'h00A1);
        @(negedge clk);
        chk_disp("t3_zero", 16'h00A0);
        chk_flag("t3_done", bus.done, 1'b1);
        chk_flag("t3_run_done", bus.running, 1'b0);
        press(1'b1, 1'b0);
        chk_flag("t3_done_clr", bus.done, 1'b0);
        press(1'b1, 1'b0);
        chk_flag("t3_no_start", bus.running, 1'b0);
        chk_disp("t3_still0", 16'h00A0);

        // 4: lap hold and release
        bus.mode = 1'b0;
        press(1'b1, 1'b0);
        repeat (8) @(negedge clk);
        press(1'b0, 1'b1);
        chk_disp("t4_lap", 16'h01A2);
        chk_flag("t4_lap_act", bus.lap_active, 1'b1);
        repeat (5) @(negedge clk);
        chk_disp("t4_frozen", 16'h01A2);
        press(1'b0, 1'b1);
        chk_disp("t4_live", 16'h02A1);
        chk_flag("t4_lap_off", bus.lap_active, 1'b0);
        press(1'b1, 1'b0);
        chk_disp("t4_stop", 16'h02A5);
        press(1'b0, 1'b1);
        chk_disp("t4_clear", 16'h00A0);

        // 5: same-cycle start_stop+lap, load in RUN ignored, saturating load
        press(1'b1, 1'b0);
        repeat (6) @(negedge clk);
        press(1'b1, 1'b1);
        chk_disp("t5_both", 16'h01A0);
        chk_flag("t5_stopped", bus.running, 1'b0);
        chk_flag("t5_nolap", bus.lap_active, 1'b0);
        press(1'b1, 1'b0);
        do_load(12'h777);
        chk_disp("t5_load_run", 16'h01A1);
        chk_flag("t5_still_run", bus.running, 1'b1);
        press(1'b1, 1'b0);
        chk_disp("t5_stop", 16'h01A5);
        do_load(12'hFA3);
        chk_disp("t5_sat", 16'h99A3);

        // 6: asynchronous reset mid-run with lap and overflow set
        press(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        press(1'b0, 1'b1);
        chk_flag("t6_pre_lap", bus.lap_active, 1'b1);
        chk_flag("t6_pre_ovf", bus.overflow, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk_disp("t6_disp", 16'h00A0);
        chk_flag("t6_running", bus.running, 1'b0);
        chk_flag("t6_lap", bus.lap_active, 1'b0);
        chk_flag("t6_ovf", bus.overflow, 1'b0);
        chk_flag("t6_done", bus.done, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        chk_flag("t6_idle", bus.running, 1'b0);
        chk_disp("t6_idle_disp", 16'h00A0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
